// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates ids at issue, captures CDB writebacks,
// answers operand queries and retires in order with mispredict flush.
module reorder_buffer #(
    parameter int ROB_SIZE_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      issue_valid,
    input  logic [4:0]                issue_rd,
    input  logic                      issue_is_branch,
    input  logic                      issue_pred_taken,
    input  logic [31:0]               issue_alt_pc,
    output logic                      rob_full,
    output logic [ROB_SIZE_WIDTH-1:0] issue_rob_id,
    output logic [ROB_SIZE_WIDTH-1:0] reg_issue_rob_id,
    output logic [4:0]                reg_issue_rd,
    input  logic                      wb_valid,
    input  logic [ROB_SIZE_WIDTH-1:0] wb_rob_id,
    input  logic [31:0]               wb_value,
    input  logic                      wb_taken,
    input  logic [ROB_SIZE_WIDTH-1:0] ask_rob_id1,
    input  logic [ROB_SIZE_WIDTH-1:0] ask_rob_id2,
    output logic [31:0]               get_value1,
    output logic [31:0]               get_value2,
    output logic                      get_ready1,
    output logic                      get_ready2,
    output logic [ROB_SIZE_WIDTH-1:0] commit_rob_id,
    output logic [4:0]                commit_rd,
    output logic [31:0]               commit_value,
    output logic                      commit_any,
    output logic                      flush,
    output logic [31:0]               flush_pc
);
    localparam int W = ROB_SIZE_WIDTH;
    localparam int N = (1 << W) - 1;
    typedef logic [W-1:0] id_t;

    // Slot 0 is never allocated, so a lookup with id 0 always sees busy=0.
    logic        busy_reg       [0:N];
    logic        ready_reg      [0:N];
    logic [4:0]  rd_reg         [0:N];
    logic [31:0] value_reg      [0:N];
    logic        is_branch_reg  [0:N];
    logic        pred_taken_reg [0:N];
    logic        taken_reg      [0:N];
    logic [31:0] alt_pc_reg     [0:N];

    id_t         head_reg, tail_reg, count_reg;
    id_t         commit_rob_id_reg;
    logic [4:0]  commit_rd_reg;
    logic [31:0] commit_value_reg;
    logic        commit_any_reg;
    logic        flush_reg;
    logic [31:0] flush_pc_reg;

    logic do_issue, do_commit, mispredict, wb_hit;

    function automatic id_t next_id(input id_t id);
        return (id == id_t'(N)) ? id_t'(1) : id + id_t'(1);
    endfunction

    assign rob_full         = (count_reg == id_t'(N));
    assign do_issue         = rdy && issue_valid && !rob_full && !flush_reg;
    assign issue_rob_id     = do_issue ? tail_reg : '0;
    assign reg_issue_rob_id = (issue_rd == 5'd0) ? '0 : issue_rob_id;
    assign reg_issue_rd     = issue_rd;

    assign wb_hit     = wb_valid && (wb_rob_id != '0) && busy_reg[wb_rob_id];
    assign do_commit  = busy_reg[head_reg] && ready_reg[head_reg] && !flush_reg;
    assign mispredict = is_branch_reg[head_reg] &&
                        (taken_reg[head_reg] != pred_taken_reg[head_reg]);

    // Two identical query ports with same-cycle CDB bypass.
    id_t         ask_id    [2];
    logic [31:0] ask_value [2];
    logic        ask_ready [2];

    assign ask_id[0] = ask_rob_id1;
    assign ask_id[1] = ask_rob_id2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_query
            always_comb begin
                ask_ready[gi] = 1'b0;
                ask_value[gi] = 32'd0;
                if (ask_id[gi] != '0 && busy_reg[ask_id[gi]]) begin
                    if (wb_valid && wb_rob_id == ask_id[gi]) begin
                        ask_ready[gi] = 1'b1;
                        ask_value[gi] = wb_value;
                    end else begin
                        ask_ready[gi] = ready_reg[ask_id[gi]];
                        ask_value[gi] = value_reg[ask_id[gi]];
                    end
                end
            end
        end
    endgenerate

    assign get_ready1 = ask_ready[0];
    assign get_value1 = ask_value[0];
    assign get_ready2 = ask_ready[1];
    assign get_value2 = ask_value[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= N; i++) begin
                busy_reg[i]  <= 1'b0;
                ready_reg[i] <= 1'b0;
            end
            head_reg          <= id_t'(1);
            tail_reg          <= id_t'(1);
            count_reg         <= '0;
            commit_rob_id_reg <= '0;
            commit_rd_reg     <= '0;
            commit_value_reg  <= '0;
            commit_any_reg    <= 1'b0;
            flush_reg         <= 1'b0;
            flush_pc_reg      <= '0;
        end else if (!rdy) begin
            commit_rob_id_reg <= '0;
            commit_rd_reg     <= '0;
            commit_value_reg  <= '0;
            commit_any_reg    <= 1'b0;
            flush_reg         <= 1'b0;
            flush_pc_reg      <= '0;
        end else begin
            commit_any_reg    <= do_commit;
            commit_rd_reg     <= do_commit ? rd_reg[head_reg] : 5'd0;
            commit_value_reg  <= do_commit ? value_reg[head_reg] : 32'd0;
            commit_rob_id_reg <= (do_commit && !mispredict && rd_reg[head_reg] != 5'd0)
                                 ? head_reg : '0;
            flush_reg         <= do_commit && mispredict;
            flush_pc_reg      <= (do_commit && mispredict) ? alt_pc_reg[head_reg] : 32'd0;

            if (do_commit && mispredict) begin
                // Wrong-path entries are discarded wholesale.
                for (int i = 0; i <= N; i++) begin
                    busy_reg[i] <= 1'b0;
                end
                head_reg  <= id_t'(1);
                tail_reg  <= id_t'(1);
                count_reg <= '0;
            end else begin
                if (wb_hit) begin
                    ready_reg[wb_rob_id] <= 1'b1;
                    value_reg[wb_rob_id] <= wb_value;
                    taken_reg[wb_rob_id] <= wb_taken;
                end
                if (do_commit) begin
                    busy_reg[head_reg] <= 1'b0;
                    head_reg           <= next_id(head_reg);
                end
                if (do_issue) begin
                    busy_reg[tail_reg]       <= 1'b1;
                    ready_reg[tail_reg]      <= 1'b0;
                    rd_reg[tail_reg]         <= issue_rd;
                    value_reg[tail_reg]      <= 32'd0;
                    is_branch_reg[tail_reg]  <= issue_is_branch;
                    pred_taken_reg[tail_reg] <= issue_pred_taken;
                    taken_reg[tail_reg]      <= 1'b0;
                    alt_pc_reg[tail_reg]     <= issue_alt_pc;
                    tail_reg                 <= next_id(tail_reg);
                end
                if (do_issue && !do_commit) begin
                    count_reg <= count_reg + id_t'(1);
                end else if (!do_issue && do_commit) begin
                    count_reg <= count_reg - id_t'(1);
                end
            end
        end
    end

    assign commit_rob_id = commit_rob_id_reg;
    assign commit_rd     = commit_rd_reg;
    assign commit_value  = commit_value_reg;
    assign commit_any    = commit_any_reg;
    assign flush         = flush_reg;
    assign flush_pc      = flush_pc_reg;

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios then random traffic, all
// compared against an in-order queue model of the buffer.
module tb_reorder_buffer;
    localparam int W = 2;
    localparam int N = (1 << W) - 1;

    logic         clk, rst, rdy;
    logic         issue_valid;
    logic [4:0]   issue_rd;
    logic         issue_is_branch, issue_pred_taken;
    logic [31:0]  issue_alt_pc;
    logic         rob_full;
    logic [W-1:0] issue_rob_id, reg_issue_rob_id;
    logic [4:0]   reg_issue_rd;
    logic         wb_valid;
    logic [W-1:0] wb_rob_id;
    logic [31:0]  wb_value;
    logic         wb_taken;
    logic [W-1:0] ask_rob_id1, ask_rob_id2;
    logic [31:0]  get_value1, get_value2;
    logic         get_ready1, get_ready2;
    logic [W-1:0] commit_rob_id;
    logic [4:0]   commit_rd;
    logic [31:0]  commit_value;
    logic         commit_any, flush;
    logic [31:0]  flush_pc;

    reorder_buffer #(.ROB_SIZE_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_is_branch(issue_is_branch), .issue_pred_taken(issue_pred_taken),
        .issue_alt_pc(issue_alt_pc), .rob_full(rob_full),
        .issue_rob_id(issue_rob_id), .reg_issue_rob_id(reg_issue_rob_id),
        .reg_issue_rd(reg_issue_rd),
        .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_value(wb_value),
        .wb_taken(wb_taken),
        .ask_rob_id1(ask_rob_id1), .ask_rob_id2(ask_rob_id2),
        .get_value1(get_value1), .get_value2(get_value2),
        .get_ready1(get_ready1), .get_ready2(get_ready2),
        .commit_rob_id(commit_rob_id), .commit_rd(commit_rd),
        .commit_value(commit_value), .commit_any(commit_any),
        .flush(flush), .flush_pc(flush_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [4:0]  rd;
        bit          ready;
        logic [31:0] value;
        bit          br;
        bit          pred;
        bit          taken;
        logic [31:0] alt;
    } ent_t;

    ent_t q[$];
    int   m_tail = 1;
    bit   m_flush = 0;
    bit   e_any = 0;
    int   e_cid = 0;
    logic [4:0]  e_rd = '0;
    logic [31:0] e_val = '0;
    logic [31:0] e_fpc = '0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int find(input int id);
        for (int i = 0; i < q.size(); i++)
            if (q[i].id == id) return i;
        return -1;
    endfunction

    function automatic logic [32:0] exp_query(input int ask);
        int k;
        k = find(ask);
        if (ask == 0 || k < 0) return 33'd0;
        if (wb_valid && int'(wb_rob_id) == ask) return {1'b1, wb_value};
        return {q[k].ready ? 1'b1 : 1'b0, q[k].value};
    endfunction

    // One clock: check combinational outputs, advance the model, check registered outputs.
    task automatic cycle();
        bit          full, ok_issue, com, mis;
        int          eid, k;
        logic [32:0] qa;
        ent_t        h, n;
        #1;
        full     = (q.size() == N);
        ok_issue = rdy && issue_valid && !full && !m_flush;
        eid      = ok_issue ? m_tail : 0;
        if (!rst) begin
            check("rob_full", 32'(rob_full), 32'(full));
            check("issue_rob_id", 32'(issue_rob_id), eid);
            check("reg_issue_rob_id", 32'(reg_issue_rob_id), (issue_rd == 5'd0) ? 0 : eid);
            check("reg_issue_rd", 32'(reg_issue_rd), 32'(issue_rd));
            qa = exp_query(int'(ask_rob_id1));
            check("get_ready1", 32'(get_ready1), 32'(qa[32]));
            check("get_value1", get_value1, qa[31:0]);
            qa = exp_query(int'(ask_rob_id2));
            check("get_ready2", 32'(get_ready2), 32'(qa[32]));
            check("get_value2", get_value2, qa[31:0]);
        end
        @(posedge clk);
        if (rst || !rdy) begin
            if (rst) begin
                q.delete();
                m_tail = 1;
            end
            e_any = 0; e_cid = 0; e_rd = '0; e_val = '0; m_flush = 0; e_fpc = '0;
        end else begin
            com = 0;
            mis = 0;
            if (!m_flush && q.size() > 0 && q[0].ready) begin
                com = 1;
                h   = q[0];
                mis = h.br && (h.taken != h.pred);
            end
            e_any   = com;
            e_rd    = com ? h.rd : 5'd0;
            e_val   = com ? h.value : 32'd0;
            e_cid   = (com && !mis && h.rd != 5'd0) ? h.id : 0;
            m_flush = mis;
            e_fpc   = mis ? h.alt : 32'd0;
            if (mis) begin
                q.delete();
                m_tail = 1;
            end else begin
                if (com) void'(q.pop_front());
                if (wb_valid) begin
                    k = find(int'(wb_rob_id));
                    if (k >= 0) begin
                        q[k].ready = 1;
                        q[k].value = wb_value;
                        q[k].taken = wb_taken;
                    end
                end
                if (ok_issue) begin
                    n.id = m_tail; n.rd = issue_rd; n.ready = 0; n.value = '0;
                    n.br = issue_is_branch; n.pred = issue_pred_taken; n.taken = 0;
                    n.alt = issue_alt_pc;
                    q.push_back(n);
                    m_tail = (m_tail % N) + 1;
                end
            end
        end
        #1;
        check("commit_any", 32'(commit_any), 32'(e_any));
        check("commit_rob_id", 32'(commit_rob_id), e_cid);
        check("flush", 32'(flush), 32'(m_flush));
        if (e_any) begin
            check("commit_rd", 32'(commit_rd), 32'(e_rd));
            check("commit_value", commit_value, e_val);
        end
        if (m_flush) check("flush_pc", flush_pc, e_fpc);
    endtask

    task automatic idle();
        rdy = 1'b1; issue_valid = 1'b0; issue_rd = '0; issue_is_branch = 1'b0;
        issue_pred_taken = 1'b0; issue_alt_pc = '0; wb_valid = 1'b0; wb_rob_id = '0;
        wb_value = '0; wb_taken = 1'b0; ask_rob_id1 = '0; ask_rob_id2 = '0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        cycle(); cycle();
        rst = 1'b0;
        check("reset_commit_any", 32'(commit_any), 0);
        check("reset_flush_pc", flush_pc, 0);

        // Fill all three slots in order.
        issue_valid = 1'b1; issue_rd = 5'd5; #1;
        check("alloc_id1", 32'(issue_rob_id), 1); cycle();
        issue_rd = 5'd6; #1;
        check("alloc_id2", 32'(issue_rob_id), 2); cycle();
        issue_rd = 5'd7; #1;
        check("alloc_id3", 32'(issue_rob_id), 3); cycle();
        issue_rd = 5'd8; #1;
        check("full_flag", 32'(rob_full), 1);
        check("full_no_alloc", 32'(issue_rob_id), 0); cycle();

        // Out-of-order writebacks retire in order.
        issue_valid = 1'b0; wb_valid = 1'b1; wb_rob_id = 2'd2; wb_value = 32'h22; cycle();
        wb_rob_id = 2'd1; wb_value = 32'h11; cycle();
        check("no_commit_on_ready_edge", 32'(commit_any), 0);
        wb_valid = 1'b0; cycle();
        check("commit1_id", 32'(commit_rob_id), 1);
        check("commit1_rd", 32'(commit_rd), 5);
        check("commit1_value", commit_value, 32'h11);
        issue_valid = 1'b1; issue_rd = 5'd9; #1;
        check("wrap_alloc_id1", 32'(issue_rob_id), 1); cycle();
        check("commit2_id", 32'(commit_rob_id), 2);
        check("commit2_value", commit_value, 32'h22);

        // Same-cycle bypass on the query port.
        issue_valid = 1'b0; wb_valid = 1'b1; wb_rob_id = 2'd3; wb_value = 32'hAB;
        ask_rob_id1 = 2'd3; #1;
        check("bypass_ready", 32'(get_ready1), 1);
        check("bypass_value", get_value1, 32'hAB); cycle();
        ask_rob_id1 = '0; wb_rob_id = 2'd1; wb_value = 32'h99; cycle();
        check("commit3_id", 32'(commit_rob_id), 3);
        check("commit3_rd", 32'(commit_rd), 7);
        wb_valid = 1'b0; cycle();
        check("commit_wrapped_value", commit_value, 32'h99);

        // Mispredicted branch flushes the whole buffer.
        rst = 1'b1; cycle(); rst = 1'b0;
        issue_valid = 1'b1; issue_is_branch = 1'b1; issue_pred_taken = 1'b1;
        issue_alt_pc = 32'h1000; issue_rd = 5'd0; cycle();
        issue_is_branch = 1'b0; issue_pred_taken = 1'b0; issue_alt_pc = '0; issue_rd = 5'd8; cycle();
        issue_valid = 1'b0; wb_valid = 1'b1; wb_rob_id = 2'd1; wb_taken = 1'b0; wb_value = '0; cycle();
        wb_valid = 1'b0; cycle();
        check("mispredict_flush", 32'(flush), 1);
        check("mispredict_pc", flush_pc, 32'h1000);
        check("mispredict_no_rd_write", 32'(commit_rob_id), 0);
        issue_valid = 1'b1; issue_rd = 5'd0; #1;
        check("issue_during_flush", 32'(issue_rob_id), 0); cycle();
        #1;
        check("issue_after_flush", 32'(issue_rob_id), 1);
        check("rd0_reg_issue_id", 32'(reg_issue_rob_id), 0); cycle();

        // rd=0 entry still retires, without a register write.
        issue_valid = 1'b0; wb_valid = 1'b1; wb_rob_id = 2'd1; wb_value = 32'h5; cycle();
        wb_valid = 1'b0; cycle();
        check("rd0_commit_any", 32'(commit_any), 1);
        check("rd0_commit_id", 32'(commit_rob_id), 0);
        check("rd0_commit_value", commit_value, 32'h5);

        // Stalled pipeline: no allocation.
        rdy = 1'b0; issue_valid = 1'b1; issue_rd = 5'd3; #1;
        check("stall_no_alloc", 32'(issue_rob_id), 0); cycle();
        rdy = 1'b1;

        for (int n = 0; n < 3000; n++) begin
            rdy              = ($urandom_range(0, 7) != 0);
            issue_valid      = 1'($urandom_range(0, 1));
            issue_rd         = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            issue_is_branch  = ($urandom_range(0, 3) == 0);
            issue_pred_taken = 1'($urandom_range(0, 1));
            issue_alt_pc     = $urandom;
            wb_valid         = 1'($urandom_range(0, 1));
            wb_rob_id        = W'($urandom_range(0, N));
            wb_value         = $urandom;
            wb_taken         = 1'($urandom_range(0, 1));
            ask_rob_id1      = W'($urandom_range(0, N));
            ask_rob_id2      = W'($urandom_range(0, N));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
